pipelined_shifter: RTL
======================

// Module: pipelined_shifter
// PURPOSE
//  Parametrised, pipelined successor to the single-cycle combinational shifter.
//  Computes SLL/SRL/SRA (and optionally ROL/ROR) on a WIDTH-bit operand.
//  Log-depth mux network is split across STAGES register stages.
//  Valid/ready handshake on both sides; full backpressure support.
//  Used by the pipelined RISC-V EX stage and multi-cycle ALU clients.
// PARAMETERS
//  WIDTH   32  operand width; power of 2, 8..64
//  STAGES  2   pipeline register stages, 1..$clog2(WIDTH)
//  TAG_W   5   sideband tag width (e.g. rd index), passed through unchanged
// PORTS
//  i_clk     in   1        clock, rising edge
//  i_rst_n   in   1        async active-low reset
//  i_valid   in   1        input beat valid
//  o_ready   out  1        shifter can accept a beat this cycle
//  i_op      in   3        000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR, others illegal
//  i_data    in   WIDTH    operand to shift
//  i_shamt   in   SHW      shift amount; SHW = $clog2(WIDTH)
//  i_tag     in   TAG_W    sideband tag
//  o_valid   out  1        result beat valid
//  i_ready   in   1        downstream accepts result
//  o_result  out  WIDTH    shifted result
//  o_tag     out  TAG_W    tag of this result
//  o_illegal out  1        i_op of this beat was illegal or not compiled in
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): all stage valid bits, o_valid, o_illegal -> 0;
//    o_result, o_tag -> 0. Takes effect immediately; in-flight beats are discarded.
//  - Shift levels: L = SHW levels; level k shifts by 2^k when shamt[k]=1.
//    Level assignment: ceil(L/STAGES) levels per stage; last stage may hold fewer.
//  - Latency: exactly STAGES cycles from accepted input to o_valid, with no stall.
//  - Global enable: en = !o_valid | i_ready. o_ready = en.
//    When en=0 every stage, including the output, holds its value.
//  - Input transfer: i_valid & o_ready. Output transfer: o_valid & i_ready.
//  - Bubbles are not collapsed; a stage valid bit of 0 propagates as a bubble.
//  - Throughput: 1 beat/cycle while i_ready=1.
//  - Beats stay in order. Max in flight = STAGES.
//    No beat is lost or duplicated under any i_ready pattern.
//  - Each stage carries op, remaining shamt bits, data, tag and illegal.
//  - SRA fill: sign bit of the original i_data, captured at stage 0.
//  - SLL/SRL fill with 0.
//  - Shift amount is SHW bits wide, so it is taken mod WIDTH.
//    shamt=0 returns i_data for every legal op.
//  - Illegal op: o_result=0, o_illegal=1, o_tag valid. The beat consumes a slot normally.
//  - Simultaneous i_valid and full pipeline with i_ready=1: the input is accepted
//    in the same cycle the output drains.
//  - o_result, o_tag, o_illegal are don't-care while o_valid=0,
//    but are held stable while o_valid=1 & i_ready=0.
// CONFIGURATION
//  SHIFTER_ROTATE_EN defined: ROL (011) and ROR (100) are supported.
//    Fill bits come from the opposite end of the operand; o_illegal=0 for them.
//  Not defined: rotate logic is absent. 011/100 are illegal:
//    o_result=0, o_illegal=1.
// TESTING
//  1. SLL 0x0000_0001 by 31 -> 0x8000_0000 after STAGES cycles, o_illegal=0.
//  2. SRA 0x8000_0000 by 4 -> 0xF800_0000; SRL same operand -> 0x0800_0000;
//     shamt=0 -> unchanged operand.
//  3. Stream 6 beats, tags 1..6, STAGES=2; hold i_ready=0 for 5 cycles mid-stream.
//     -> o_ready=0 during the stall; results held stable; all 6 emerge in order.
//  4. Assert i_rst_n=0 with 2 beats in flight -> o_valid=0 immediately.
//     Once reset is released, no stale beat appears.
//  5. ROR 0x0000_0001 by 1 -> 0x8000_0000 with SHIFTER_ROTATE_EN.
//     Without it -> 0, o_illegal=1. Op 111 -> 0, o_illegal=1 in both builds.
//  6. Sweep WIDTH=8/32/64 and STAGES=1..SHW: random op/data/shamt vs. golden model.
//     Continuous i_valid=1, i_ready=1 -> one result per cycle.

Source files
------------

// File: rtl/pipelined_shifter.sv
// -----------------------------------------------------------------------------
// pipelined_shifter
//   Pipelined barrel shifter: SLL / SRL / SRA, plus ROL / ROR when the macro
//   SHIFTER_ROTATE_EN is defined. The SHW = $clog2(WIDTH) mux levels (level k
//   shifts by 2^k) are distributed ceil(SHW/STAGES) per register stage, so a
//   beat takes exactly STAGES cycles. One global enable
//   (!o_valid | i_ready) advances or freezes the whole pipe.
//
//   Macro: SHIFTER_ROTATE_EN -- compiles in ROL (011) / ROR (100); without it
//   those opcodes report o_illegal with a zero result.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_valid / o_ready     input handshake
//   i_op[2:0]             000 SLL, 001 SRL, 010 SRA, 011 ROL, 100 ROR
//   i_data[WIDTH-1:0]     operand
//   i_shamt[SHW-1:0]      shift amount (mod WIDTH by construction)
//   i_tag[TAG_W-1:0]      sideband tag, passed through
//   o_valid / i_ready     output handshake
//   o_result, o_tag       shifted result and its tag
//   o_illegal             opcode of this beat was illegal / not compiled in
// -----------------------------------------------------------------------------
module pipelined_shifter #(
    parameter  int WIDTH  = 32,
    parameter  int STAGES = 2,
    parameter  int TAG_W  = 5,
    localparam int SHW    = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SHW-1:0]   i_shamt,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_illegal
);
    // Levels per stage; trailing stages may own fewer (or zero) levels.
    localparam int LPS = (SHW + STAGES - 1) / STAGES;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef struct packed {
        logic [2:0]       op;
        logic [SHW-1:0]   shamt;
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             illegal;
        logic             sign;    // MSB of the original operand, SRA fill
    } beat_t;

    // Apply the mux levels owned by stage s to one beat.
    function automatic beat_t f_stage(input beat_t b, input int s);
        beat_t            r;
        logic [WIDTH-1:0] fill;
        int               n;
        r = b;
        for (int k = 0; k < SHW; k++) begin
            if (k >= s * LPS && k < (s + 1) * LPS && r.shamt[k]) begin
                n    = 1 << k;
                fill = r.sign ? ~({WIDTH{1'b1}} >> n) : '0;
                case (r.op)
                    OP_SLL:  r.data = r.data << n;
                    OP_SRL:  r.data = r.data >> n;
                    OP_SRA:  r.data = (r.data >> n) | fill;
`ifdef SHIFTER_ROTATE_EN
                    OP_ROL:  r.data = (r.data << n) | (r.data >> (WIDTH - n));
                    OP_ROR:  r.data = (r.data >> n) | (r.data << (WIDTH - n));
`endif
                    default: r.data = '0;
                endcase
            end
        end
        return r;
    endfunction

    logic              w_en;
    logic              w_illegal;
    beat_t             w_in;
    beat_t             w_pl [STAGES];
    beat_t             r_pl [STAGES];
    logic [STAGES-1:0] r_vld;
    logic [STAGES:0]   w_vld_pipe;
    logic              w_unused_tail;

    assign w_en       = !r_vld[STAGES-1] || i_ready;
    assign w_vld_pipe = {r_vld, i_valid};

    always_comb begin
        w_illegal = 1'b1;
        case (i_op)
            OP_SLL, OP_SRL, OP_SRA: w_illegal = 1'b0;
`ifdef SHIFTER_ROTATE_EN
            OP_ROL, OP_ROR:         w_illegal = 1'b0;
`endif
            default:                w_illegal = 1'b1;
        endcase
    end

    // Illegal beats travel with a zero operand, so every level keeps them at 0.
    always_comb begin
        w_in.op      = i_op;
        w_in.shamt   = i_shamt;
        w_in.data    = w_illegal ? '0 : i_data;
        w_in.tag     = i_tag;
        w_in.illegal = w_illegal;
        w_in.sign    = !w_illegal && i_data[WIDTH-1];
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_link
        if (s == 0) begin : g_head
            assign w_pl[s] = w_in;
        end else begin : g_body
            assign w_pl[s] = r_pl[s-1];
        end
    end

    // Bubbles are registered like beats: valid bits shift in lockstep with data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld <= '0;
            for (int s = 0; s < STAGES; s++) r_pl[s] <= '0;
        end else if (w_en) begin
            r_vld <= w_vld_pipe[STAGES-1:0];
            for (int s = 0; s < STAGES; s++) r_pl[s] <= f_stage(w_pl[s], s);
        end
    end

    assign o_ready   = w_en;
    assign o_valid   = r_vld[STAGES-1];
    assign o_result  = r_pl[STAGES-1].data;
    assign o_tag     = r_pl[STAGES-1].tag;
    assign o_illegal = r_pl[STAGES-1].illegal;

    // Control fields are dead once the last stage has applied its levels.
    assign w_unused_tail = ^{r_pl[STAGES-1].op, r_pl[STAGES-1].shamt,
                             r_pl[STAGES-1].sign, w_vld_pipe[STAGES]};
endmodule
